uart_tx: RTL and testbench

Serial transmitter for the UART peripheral: accepts a byte from the UART control block via a one-cycle `tx_start` strobe and shifts it onto the `tx` line as an 8N1 frame. Framing is start bit, 8 data bits LSB first, optional parity, and one stop bit. It reports `tx_busy` while a frame is in flight and pulses `tx_end` when the stop bit completes. The control block uses `tx_end` to raise its transmit interrupt. Sits between the UART control block and the chip TX pad.

---
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Handshake bundle between the UART control block (master) and the serial transmitter (slave).
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_end;
  logic       tx;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_end,
    input  tx
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_end,
    output tx
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered outputs; define UART_TX_PARITY_EN to insert an even
// parity bit after the data bits (8E1 framing, 11 bit periods per frame).
module uart_tx #(
  parameter int unsigned DIV   = 868,
  parameter int unsigned CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DIV - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif
  logic             line_q;
  logic             busy_q;
  logic             end_q;
  logic             wrap;

  assign wrap = (cnt == LastCnt);

  // Outputs are updated on the same edge as the state change, so the line level
  // is stable for a whole bit period and never glitches between bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= StIdle;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
      line_q <= 1'b1;
      busy_q <= 1'b0;
      end_q  <= 1'b0;
    end else begin
      end_q <= 1'b0;
      unique case (state)
        StIdle: begin
          line_q <= 1'b1;
          busy_q <= 1'b0;
          if (bus.tx_start) begin
            shift  <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            par    <= ^bus.tx_data;
`endif
            cnt    <= '0;
            idx    <= '0;
            line_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= StStart;
          end
        end
        StStart: begin
          if (wrap) begin
            cnt    <= '0;
            idx    <= '0;
            line_q <= shift[0];
            state  <= StData;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StData: begin
          if (wrap) begin
            cnt   <= '0;
            shift <= {1'b0, shift[7:1]};
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              line_q <= par;
              state  <= StParity;
`else
              line_q <= 1'b1;
              state  <= StStop;
`endif
            end else begin
              idx    <= idx + 3'd1;
              line_q <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (wrap) begin
            cnt    <= '0;
            line_q <= 1'b1;
            state  <= StStop;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        StStop: begin
          if (wrap) begin
            cnt    <= '0;
            line_q <= 1'b1;
            busy_q <= 1'b0;
            end_q  <= 1'b1;
            state  <= StIdle;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt    <= '0;
          line_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= StIdle;
        end
      endcase
    end
  end

  assign bus.tx      = line_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_end  = end_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model compared every cycle,
// plus directed frames with hand-computed line levels.
module tb_uart_tx;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  uart_tx_if u_if ();

  uart_tx #(
    .DIV   (DIV),
    .CNT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of NB line levels, each held DIV cycles.
  logic        exp_tx   = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_end  = 1'b0;
  int          left     = 0;
  int          elapsed  = 0;
  logic [10:0] fb       = '0;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int j = 0; j < 8; j++) f[j+1] = d[j];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      left = 0; elapsed = 0; exp_tx = 1'b1; exp_busy = 1'b0; exp_end = 1'b0;
    end else begin
      exp_end = 1'b0;
      if (left > 0) begin
        left--;
        elapsed++;
        if (left == 0) exp_end = 1'b1;
      end else if (u_if.tx_start) begin
        fb      = frame_of(u_if.tx_data);
        left    = NB * DIV;
        elapsed = 0;
      end
      exp_busy = (left > 0);
      exp_tx   = (left > 0) ? fb[elapsed / DIV] : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("cyc_tx", 32'(u_if.tx), 32'(exp_tx));
    check("cyc_busy", 32'(u_if.tx_busy), 32'(exp_busy));
    check("cyc_end", 32'(u_if.tx_end), 32'(exp_end));
  end

  logic cap_tx   [0:127];
  logic cap_busy [0:127];
  logic cap_end  [0:127];

  // Strobe d at negedge 0; capture outputs at negedges 1..n; optional extra strobe at extra_at.
  task automatic run_frame(input logic [7:0] d, input int n, input int extra_at,
                           input logic [7:0] extra_d);
    @(negedge clk);
    u_if.tx_start = 1'b1;
    u_if.tx_data  = d;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cap_tx[i]     = u_if.tx;
      cap_busy[i]   = u_if.tx_busy;
      cap_end[i]    = u_if.tx_end;
      u_if.tx_start = (i == extra_at);
      u_if.tx_data  = (i == extra_at) ? extra_d : 8'h00;
    end
  endtask

  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = cap_tx[base + DIV * (k + 1) + 1];
    return b;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (cap_busy[i]) c++;
    return c;
  endfunction

  function automatic int count_end(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (cap_end[i]) c++;
    return c;
  endfunction

  function automatic int first_end(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (cap_end[i]) return i;
    return -1;
  endfunction

  logic [9:0] a5_bits;
  int         n_end;

  initial begin
    u_if.tx_start = 1'b0;
    u_if.tx_data  = 8'h00;
    a5_bits       = 10'b11_0100_1010;  // bit i = level of bit period i

    // Reset held 3 cycles, then idle.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(u_if.tx), 32'd1);
    check("rst_busy", 32'(u_if.tx_busy), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_tx", 32'(u_if.tx), 32'd1);
    check("idle_end", 32'(u_if.tx_end), 32'd0);

`ifndef UART_TX_PARITY_EN
    // 8'hA5: literal line levels, busy length and tx_end position.
    run_frame(8'hA5, 44, 0, 8'h00);
    for (int k = 0; k < 10; k++)
      check($sformatf("a5_bit%0d", k), 32'(cap_tx[DIV * k + 2]), 32'(a5_bits[k]));
    check("a5_busy_len", 32'(count_busy(1, 44)), 32'd40);
    check("a5_end_cnt", 32'(count_end(1, 44)), 32'd1);
    check("a5_end_at", 32'(first_end(1, 44)), 32'd41);
`else
    // 8'h07 with even parity: parity bit 1, 44-cycle frame.
    run_frame(8'h07, 48, 0, 8'h00);
    check("p07_data", 32'(decode(1)), 32'h07);
    check("p07_parity", 32'(cap_tx[DIV * 9 + 2]), 32'd1);
    check("p07_stop", 32'(cap_tx[DIV * 10 + 2]), 32'd1);
    check("p07_busy_len", 32'(count_busy(1, 48)), 32'd44);
    check("p07_end_at", 32'(first_end(1, 48)), 32'd45);
`endif

    // 8'h3C with an ignored 8'hFF strobe mid-frame.
    run_frame(8'h3C, NB * DIV + 8, 10, 8'hFF);
    check("3c_data", 32'(decode(1)), 32'h3C);
    check("3c_end_cnt", 32'(count_end(1, NB * DIV + 8)), 32'd1);
    check("3c_busy_len", 32'(count_busy(1, NB * DIV + 8)), 32'(NB * DIV));
    check("3c_idle_after", 32'(cap_tx[NB * DIV + 8]), 32'd1);

    // Back-to-back: 8'h00 strobed in the tx_end cycle.
    run_frame(8'h96, 2 * NB * DIV + 5, NB * DIV + 1, 8'h00);
    check("b2b_first", 32'(decode(1)), 32'h96);
    check("b2b_end1", 32'(cap_end[NB * DIV + 1]), 32'd1);
    check("b2b_gap_tx", 32'(cap_tx[NB * DIV + 1]), 32'd1);
    check("b2b_start_tx", 32'(cap_tx[NB * DIV + 2]), 32'd0);
    check("b2b_start_busy", 32'(cap_busy[NB * DIV + 2]), 32'd1);
    check("b2b_second", 32'(decode(NB * DIV + 2)), 32'h00);
    check("b2b_stop2", 32'(cap_tx[NB * DIV + 2 + DIV * (NB - 1) + 1]), 32'd1);
    check("b2b_end_cnt", 32'(count_end(1, 2 * NB * DIV + 5)), 32'd2);
    check("b2b_end2_at", 32'(first_end(NB * DIV + 2, 2 * NB * DIV + 5)), 32'(2 * NB * DIV + 2));

    // Asynchronous reset 15 cycles into an 8'h55 frame.
    @(negedge clk);
    u_if.tx_start = 1'b1;
    u_if.tx_data  = 8'h55;
    @(negedge clk);
    u_if.tx_start = 1'b0;
    u_if.tx_data  = 8'h00;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", 32'(u_if.tx_busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("arst_tx", 32'(u_if.tx), 32'd1);
    check("arst_busy", 32'(u_if.tx_busy), 32'd0);
    n_end = 0;
    repeat (2) begin
      @(negedge clk);
      if (u_if.tx_end) n_end++;
    end
    rst = 1'b1;
    repeat (NB * DIV) begin
      @(negedge clk);
      if (u_if.tx_end) n_end++;
    end
    check("arst_no_end", 32'(n_end), 32'd0);
    check("arst_idle_tx", 32'(u_if.tx), 32'd1);

    run_frame(8'h81, NB * DIV + 4, 0, 8'h00);
    check("81_data", 32'(decode(1)), 32'h81);
    check("81_end_at", 32'(first_end(1, NB * DIV + 4)), 32'(NB * DIV + 1));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
